// File: rtl/accumulator_reg.sv
`default_nettype none
// ============================================================================
//  Module      : accumulator_reg
//  Description : Parametrised A register between the shared bus and the ALU.
//                Full, lower-half and upper-half bus loads, clear, increment,
//                decrement, and a multi-cycle shift/rotate by a programmable
//                amount with a Busy/Done handshake. Supplies Zero/Neg/Carry
//                status to the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module accumulator_reg #(
    parameter  int WIDTH = 8,
    localparam int HALF  = WIDTH / 2,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [WIDTH-1:0] BusIn,
    input  logic             Ain,
    input  logic             ALowerIn,
    input  logic             AUpperIn,
    input  logic             AClr,
    input  logic             AInc,
    input  logic             ADec,
    input  logic             AShl,
    input  logic             AShr,
    input  logic             ARot,
    input  logic [SHW-1:0]   ShAmt,
    input  logic             Aout,
    output logic [WIDTH-1:0] BusOut,
    output logic [WIDTH-1:0] ALUIn,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    // An odd or tiny width makes the half loads meaningless; stop elaboration.
    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_badWidth
            $error("accumulator_reg: WIDTH must be even and at least 4");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WIDTH:0] c_ONE_EXT = (WIDTH + 1)'(1);
    localparam logic [SHW-1:0] c_CNT_ONE = SHW'(1);

    // IDLE command decode, already resolved to the single winning command
    localparam logic [2:0] c_CMD_NONE  = 3'd0;
    localparam logic [2:0] c_CMD_CLR   = 3'd1;
    localparam logic [2:0] c_CMD_LOAD  = 3'd2;
    localparam logic [2:0] c_CMD_LOWER = 3'd3;
    localparam logic [2:0] c_CMD_UPPER = 3'd4;
    localparam logic [2:0] c_CMD_INC   = 3'd5;
    localparam logic [2:0] c_CMD_DEC   = 3'd6;
    localparam logic [2:0] c_CMD_SHIFT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_accum;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [SHW-1:0]   r_count;     // shift steps still to perform
    logic             r_dirLeft;   // direction latched at shift start
    logic             r_rotate;    // rotate/shift mode latched at shift start

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [2:0]       w_cmd;
    logic [WIDTH:0]   w_incSum;    // {wrap, A+1}
    logic [WIDTH:0]   w_decDiff;   // {borrow, A-1}
    logic [WIDTH-1:0] w_lowerLoad;
    logic [WIDTH-1:0] w_upperLoad;
    logic             w_leftFill;
    logic             w_rightFill;

    assign w_incSum    = {1'b0, r_accum} + c_ONE_EXT;
    assign w_decDiff   = {1'b0, r_accum} - c_ONE_EXT;
    assign w_lowerLoad = {r_accum[WIDTH-1:HALF], BusIn[HALF-1:0]};
    assign w_upperLoad = {BusIn[HALF-1:0], r_accum[HALF-1:0]};
    // A rotate feeds the departing bit back in; a logical shift fills zero.
    assign w_leftFill  = r_rotate & r_accum[WIDTH-1];
    assign w_rightFill = r_rotate & r_accum[0];

    // Resolve simultaneous commands to the single highest-priority one.
    // Both half loads together behave exactly like a full load.
    always_comb begin
        w_cmd = c_CMD_NONE;
        if (AClr) begin
            w_cmd = c_CMD_CLR;
        end else if (Ain || (ALowerIn && AUpperIn)) begin
            w_cmd = c_CMD_LOAD;
        end else if (ALowerIn) begin
            w_cmd = c_CMD_LOWER;
        end else if (AUpperIn) begin
            w_cmd = c_CMD_UPPER;
        end else if (AInc) begin
            w_cmd = c_CMD_INC;
        end else if (ADec) begin
            w_cmd = c_CMD_DEC;
        end else if (AShl || AShr) begin
            w_cmd = c_CMD_SHIFT;
        end
    end

    // Register, carry and handshake sequencing across IDLE/SHIFT/DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_accum   <= '0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_dirLeft <= 1'b0;
            r_rotate  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    case (w_cmd)
                        c_CMD_CLR: begin
                            r_accum <= '0;
                            r_carry <= 1'b0;
                        end
                        c_CMD_LOAD: begin
                            r_accum <= BusIn;
                        end
                        c_CMD_LOWER: begin
                            r_accum <= w_lowerLoad;
                        end
                        c_CMD_UPPER: begin
                            r_accum <= w_upperLoad;
                        end
                        c_CMD_INC: begin
                            {r_carry, r_accum} <= w_incSum;
                        end
                        c_CMD_DEC: begin
                            {r_carry, r_accum} <= w_decDiff;
                        end
                        c_CMD_SHIFT: begin
                            if (ShAmt == '0) begin
                                // Nothing to move: acknowledge straight away.
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_count   <= ShAmt;
                                r_dirLeft <= AShl;   // left wins a tie
                                r_rotate  <= ARot;
                                r_busy    <= 1'b1;
                                r_state   <= S_SHIFT;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                S_SHIFT: begin
                    // One bit position per clock; Carry catches the bit leaving.
                    if (r_dirLeft) begin
                        {r_carry, r_accum} <= {r_accum, w_leftFill};
                    end else begin
                        {r_accum, r_carry} <= {w_rightFill, r_accum};
                    end
                    r_count <= r_count - c_CNT_ONE;
                    if (r_count == c_CNT_ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Single-cycle completion pulse; commands are ignored here.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: status and data views follow A in every state
    // ------------------------------------------------------------------------
    assign BusOut = Aout ? r_accum : '0;
    assign ALUIn  = r_accum;
    assign Zero   = (r_accum == '0);
    assign Neg    = r_accum[WIDTH-1];
    assign Carry  = r_carry;
    assign Busy   = r_busy;
    assign Done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accumulator_reg
//  Description : Self-checking bench for accumulator_reg (WIDTH = 8).
//                Directed vector table, hand-written shift/abort sequences and
//                randomized commands against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] BusIn;
    logic         Ain, ALowerIn, AUpperIn, AClr, AInc, ADec;
    logic         AShl, AShr, ARot, Aout;
    logic [2:0]   ShAmt;
    logic [W-1:0] BusOut, ALUIn;
    logic         Zero, Neg, Carry, Busy, Done;

    int nCompared   = 0;
    int nMismatched = 0;

    // model state
    logic [W-1:0] mA;
    logic         mC;

    accumulator_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .BusIn    (BusIn),
        .Ain      (Ain),
        .ALowerIn (ALowerIn),
        .AUpperIn (AUpperIn),
        .AClr     (AClr),
        .AInc     (AInc),
        .ADec     (ADec),
        .AShl     (AShl),
        .AShr     (AShr),
        .ARot     (ARot),
        .ShAmt    (ShAmt),
        .Aout     (Aout),
        .BusOut   (BusOut),
        .ALUIn    (ALUIn),
        .Zero     (Zero),
        .Neg      (Neg),
        .Carry    (Carry),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, ain, lo, up, inc, dec, aout;
        logic [7:0] bus;
        logic [7:0] expA;
        logic       expC;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearCmds;
        Ain = 0; ALowerIn = 0; AUpperIn = 0; AClr = 0; AInc = 0; ADec = 0;
        AShl = 0; AShr = 0; ARot = 0; ShAmt = 3'd0;
    endtask

    // Full observable state against the model, with Busy/Done expected idle.
    task automatic checkState(input string tag);
        check({tag, ".A"},      {24'd0, ALUIn}, {24'd0, mA});
        check({tag, ".Carry"},  {31'd0, Carry}, {31'd0, mC});
        check({tag, ".BusOut"}, {24'd0, BusOut}, {24'd0, (Aout ? mA : 8'h00)});
        check({tag, ".Zero"},   {31'd0, Zero},  {31'd0, (mA == 8'h00)});
        check({tag, ".Neg"},    {31'd0, Neg},   {31'd0, mA[7]});
        check({tag, ".Busy"},   {31'd0, Busy},  32'd0);
    endtask

    // Value after k single-bit moves, from plain arithmetic on the start value.
    function automatic logic [8:0] shiftModel(input logic [7:0] a0, input logic left,
                                              input logic rot, input int k);
        logic [15:0] wide;
        logic [7:0]  res;
        logic        cy;
        wide = {8'h00, a0};
        if (left) begin
            res = 8'((wide << k) | (rot ? (wide >> (8 - k)) : 16'h0));
            cy  = a0[8 - k];
        end else begin
            res = 8'((wide >> k) | (rot ? (wide << (8 - k)) : 16'h0));
            cy  = a0[k - 1];
        end
        return {cy, res};
    endfunction

    // Start a shift from IDLE on the current model value and follow it to IDLE.
    // With junk set, load/clear commands are held asserted throughout.
    task automatic runShift(input logic shl, input logic shr, input logic rot,
                            input logic [2:0] amt, input logic junk, input string tag);
        logic [7:0] a0;
        logic [8:0] e;
        a0 = mA;
        clearCmds();
        AShl = shl; AShr = shr; ARot = rot; ShAmt = amt;
        step();
        clearCmds();
        if (junk) begin
            Ain = 1; AClr = 1; AInc = 1; BusIn = 8'hAA;
        end
        if (amt == 3'd0) begin
            check({tag, ".zeroDone"}, {31'd0, Done}, 32'd1);
            check({tag, ".zeroBusy"}, {31'd0, Busy}, 32'd0);
            check({tag, ".zeroA"},    {24'd0, ALUIn}, {24'd0, mA});
            check({tag, ".zeroC"},    {31'd0, Carry}, {31'd0, mC});
        end else begin
            check({tag, ".startBusy"}, {31'd0, Busy}, 32'd1);
            check({tag, ".startA"},    {24'd0, ALUIn}, {24'd0, a0});
            for (int k = 1; k <= int'(amt); k++) begin
                step();
                e = shiftModel(a0, shl, rot, k);
                check({tag, ".stepA"}, {24'd0, ALUIn}, {24'd0, e[7:0]});
                if (k < int'(amt)) begin
                    check({tag, ".stepBusy"}, {31'd0, Busy}, 32'd1);
                    check({tag, ".stepDone"}, {31'd0, Done}, 32'd0);
                end else begin
                    check({tag, ".endBusy"}, {31'd0, Busy}, 32'd0);
                    check({tag, ".endDone"}, {31'd0, Done}, 32'd1);
                    check({tag, ".endC"},    {31'd0, Carry}, {31'd0, e[8]});
                    check({tag, ".endNeg"},  {31'd0, Neg},  {31'd0, e[7]});
                end
            end
            e  = shiftModel(a0, shl, rot, int'(amt));
            mA = e[7:0];
            mC = e[8];
        end
        step();
        check({tag, ".doneDrop"}, {31'd0, Done}, 32'd0);
        clearCmds();
        checkState({tag, ".after"});
    endtask

    task automatic applyOp(input logic clr, input logic ain, input logic lo, input logic up,
                           input logic inc, input logic dec, input logic [7:0] bus);
        clearCmds();
        AClr = clr; Ain = ain; ALowerIn = lo; AUpperIn = up; AInc = inc; ADec = dec;
        BusIn = bus;
        step();
        clearCmds();
    endtask

    initial begin
        vecs[0]  = '{0,1,0,0,0,0,1, 8'h5C, 8'h5C, 0};
        vecs[1]  = '{0,0,1,0,0,0,0, 8'hDE, 8'h5E, 0};
        vecs[2]  = '{0,0,0,1,0,0,1, 8'h03, 8'h3E, 0};
        vecs[3]  = '{0,0,0,0,0,0,0, 8'h77, 8'h3E, 0};
        vecs[4]  = '{0,0,1,1,0,0,1, 8'hA7, 8'hA7, 0};
        vecs[5]  = '{0,1,0,0,0,0,0, 8'hFF, 8'hFF, 0};
        vecs[6]  = '{0,0,0,0,1,0,1, 8'h00, 8'h00, 1};
        vecs[7]  = '{0,0,0,0,0,1,1, 8'h00, 8'hFF, 1};
        vecs[8]  = '{0,0,0,0,1,0,0, 8'h00, 8'h00, 1};
        vecs[9]  = '{0,0,0,0,1,0,0, 8'h00, 8'h01, 0};
        vecs[10] = '{0,1,0,0,0,0,0, 8'hFF, 8'hFF, 0};
        vecs[11] = '{0,0,0,0,1,0,0, 8'h00, 8'h00, 1};
        vecs[12] = '{0,1,0,0,0,0,1, 8'h33, 8'h33, 1};
        vecs[13] = '{1,1,0,0,0,0,1, 8'hAA, 8'h00, 0};
        vecs[14] = '{0,0,1,0,0,1,0, 8'h12, 8'h02, 0};
        vecs[15] = '{0,0,0,0,1,1,0, 8'h00, 8'h03, 0};
        vecs[16] = '{0,0,0,0,0,1,1, 8'h00, 8'h02, 0};
        vecs[17] = '{0,1,0,0,1,0,1, 8'h80, 8'h80, 0};
        vecs[18] = '{0,0,0,0,0,1,1, 8'h00, 8'h7F, 0};

        clearCmds();
        BusIn = 8'h00; Aout = 0; rst = 0;
        mA = 8'h00; mC = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkState("reset");
        check("reset.Done", {31'd0, Done}, 32'd0);
        rst = 1;
        step();
        checkState("postReset");

        // ---- directed vector table ----
        for (int i = 0; i < 19; i++) begin
            Aout = vecs[i].aout;
            applyOp(vecs[i].clr, vecs[i].ain, vecs[i].lo, vecs[i].up,
                    vecs[i].inc, vecs[i].dec, vecs[i].bus);
            mA = vecs[i].expA;
            mC = vecs[i].expC;
            checkState($sformatf("vec%0d", i));
        end

        // ---- asynchronous reset from IDLE with Carry set ----
        applyOp(0,1,0,0,0,0, 8'hFF);
        applyOp(0,0,0,0,1,0, 8'h00);
        applyOp(0,1,0,0,0,0, 8'h5C);
        mA = 8'h5C; mC = 1'b1;
        checkState("preReset");
        #2 rst = 0;
        #1;
        mA = 8'h00; mC = 1'b0;
        checkState("asyncReset");
        @(negedge clk);
        rst = 1;
        step();

        // ---- shift left 0x5C by 3 with load/clear held during busy ----
        Aout = 1;
        applyOp(0,1,0,0,0,0, 8'h5C);
        mA = 8'h5C; mC = 1'b0;
        runShift(1, 0, 0, 3'd3, 1, "shl3");
        check("shl3.final", {24'd0, ALUIn}, 32'hE0);

        // ---- rotate right 0x5C by 4 ----
        applyOp(0,1,0,0,0,0, 8'h5C);
        mA = 8'h5C;
        runShift(0, 1, 1, 3'd4, 0, "ror4");
        check("ror4.final", {24'd0, ALUIn}, 32'hC5);

        // ---- zero amount, and both directions requested (left wins) ----
        runShift(1, 0, 1, 3'd0, 1, "amt0");
        applyOp(0,1,0,0,0,0, 8'h81);
        mA = 8'h81;
        runShift(1, 1, 1, 3'd1, 0, "both");
        check("both.final", {24'd0, ALUIn}, 32'h03);

        // ---- reset mid-shift aborts without a Done pulse ----
        applyOp(0,1,0,0,0,0, 8'h5C);
        mA = 8'h5C;
        AShl = 1; ShAmt = 3'd5;
        step();
        clearCmds();
        step();
        step();
        #2 rst = 0;
        #1;
        mA = 8'h00; mC = 1'b0;
        checkState("abort");
        check("abort.Done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort.noDone", {31'd0, Done}, 32'd0);
        end
        checkState("abortIdle");

        // ---- randomized commands against the model ----
        for (int it = 0; it < 250; it++) begin
            logic c, a, l, u, in, de, sl, sr;
            logic [7:0] b;
            c  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 5) == 0);
            l  = ($urandom_range(0, 5) == 0);
            u  = ($urandom_range(0, 5) == 0);
            in = ($urandom_range(0, 5) == 0);
            de = ($urandom_range(0, 5) == 0);
            sl = ($urandom_range(0, 2) == 0);
            sr = ($urandom_range(0, 2) == 0);
            b  = 8'($urandom);
            Aout = 1'($urandom);
            if (c | a | l | u | in | de) begin
                applyOp(c, a, l, u, in, de, b);
                if (c) begin
                    mA = 8'h00; mC = 1'b0;
                end else if (a || (l && u)) begin
                    mA = b;
                end else if (l) begin
                    mA = {mA[7:4], b[3:0]};
                end else if (u) begin
                    mA = {b[3:0], mA[3:0]};
                end else if (in) begin
                    mC = (mA == 8'hFF);
                    mA = mA + 8'h01;
                end else begin
                    mC = (mA == 8'h00);
                    mA = mA - 8'h01;
                end
                checkState("rand.op");
            end else if (sl | sr) begin
                runShift(sl, sr, 1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), "rand.sh");
            end else begin
                applyOp(0,0,0,0,0,0, b);
                checkState("rand.hold");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accumulator_reg.md
Name: accumulator_reg

Overview:
Parametrised successor to the SAP accumulator. A WIDTH-bit A register with full, lower-half and upper-half bus loads, clear, increment and decrement. Adds multi-cycle shift and rotate by a programmable amount, using a Busy/Done handshake. Sits between the shared bus (BusIn/BusOut) and the ALU operand input (ALUIn), and also supplies Zero/Neg/Carry status to the controller.

Parameters:
WIDTH, 8, register width in bits; must be even and at least 4. HALF = WIDTH/2 is derived, not overridable.
SHW, $clog2(WIDTH), width of the shift-amount field; derived.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset
BusIn  in  WIDTH  bus data to load
Ain  in  1  load all WIDTH bits from BusIn
ALowerIn  in  1  load BusIn[HALF-1:0] into A[HALF-1:0]; upper half held
AUpperIn  in  1  load BusIn[HALF-1:0] into A[WIDTH-1:HALF]; lower half held
AClr  in  1  clear A and Carry
AInc  in  1  A <= A+1
ADec  in  1  A <= A-1
AShl  in  1  start left shift/rotate
AShr  in  1  start right shift/rotate
ARot  in  1  sampled at start: 1 = rotate, 0 = logical shift (zero fill)
ShAmt  in  SHW  shift amount, sampled at start
Aout  in  1  drive A onto BusOut
BusOut  out  WIDTH  A when Aout=1, else all zeros (combinational)
ALUIn  out  WIDTH  always A (combinational)
Zero  out  1  A == 0 (combinational)
Neg  out  1  A[WIDTH-1] (combinational)
Carry  out  1  registered carry/borrow/last shifted-out bit
Busy  out  1  high while a shift is in progress
Done  out  1  one-cycle pulse when a shift completes

Behaviour:
- Reset (rst low, asynchronous): A=0, Carry=0, state=IDLE, Busy=0, Done=0, shift counter=0. Reset mid-shift aborts the shift immediately; no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE command priority, highest first:
  - AClr
  - Ain
  - ALowerIn/AUpperIn: both asserted together = full load
  - AInc
  - ADec
  - AShl
  - AShr
  - Only the highest-priority asserted command executes.
- Loads leave Carry unchanged. AClr clears A and Carry.
- AInc: Carry=1 only when A wraps from all-ones to 0, else Carry=0.
- ADec: Carry=1 (borrow) only when A wraps from 0 to all-ones, else Carry=0.
- Shift start (IDLE):
  - ShAmt=0: go to DONE, A and Carry unchanged.
  - ShAmt=N>0: latch direction, ARot and N into the counter, go to SHIFT, Busy=1 from the next cycle.
- SHIFT: one bit position per clock.
  - Carry takes the bit leaving the register: MSB for left, LSB for right.
  - Fill bit is 0 for shift, or the leaving bit for rotate.
  - Counter decrements each step; after the Nth step go to DONE.
  - Busy is high for exactly N cycles.
- DONE: Busy=0, Done=1 for one cycle, then IDLE. Commands presented during DONE are ignored.
- While Busy=1 (and in DONE), every command input is ignored; BusIn changes have no effect.
- Aout, BusOut, ALUIn, Zero and Neg are valid in every state and track A during shifting.
- Simultaneous AShl and AShr: AShl wins.

Test Plan:
- Reset: rst low mid-cycle -> A=0x00, Carry=0, Busy=0 asynchronously; Zero=1.
- Half loads: Ain with BusIn=0x5C -> A=0x5C; then ALowerIn with BusIn=0xDE -> A=0x5E; then AUpperIn with BusIn=0x03 -> A=0x3E. Aout=1 -> BusOut=0x3E; Aout=0 -> BusOut=0x00.
- Shift left: A=0x5C, AShl, ARot=0, ShAmt=3 -> Busy high 3 cycles, intermediate A=0xB8, 0x70, 0xE0; Done pulse; final A=0xE0, Carry=0, Neg=1.
- Rotate right: A=0x5C, AShr, ARot=1, ShAmt=4 -> A steps 0x2E, 0x17, 0x8B, 0xC5; Carry=1; Done one cycle after the 4th step.
- Inc/dec wrap: A=0xFF, AInc -> A=0x00, Carry=1, Zero=1; then ADec -> A=0xFF, Carry=1; then AInc -> A=0x00; AInc again -> A=0x01, Carry=0.
- Busy lockout and abort:
  - Ain with BusIn=0xAA during Busy -> A unaffected.
  - ShAmt=0 -> Done next cycle, Busy never high.
  - rst low mid-shift -> A=0, no Done pulse.
  - AClr and Ain together -> A=0.
